// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first,
// one bit per clock, with valid/ready handshakes on operands and result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q, carry_q, in_ready_q, out_valid_q;

  logic             s_d, c_d;
  logic [WIDTH:0]   s_ext_d;
  logic [WIDTH-1:0] s_sh_d;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder cell on the current LSBs; the new sum bit enters the top of S_sh.
  always_comb begin
    s_d     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_d     = maj3(a_sh_q[0], b_sh_q[0], c_q);
    s_ext_d = {s_d, s_sh_q};
    s_sh_d  = WIDTH'(s_ext_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            c_q        <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          c_q    <= c_d;
          s_sh_q <= s_sh_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Result registers update only here, so partial sums never reach the outputs.
          if (cnt_q == LAST_BIT) begin
            sum_q       <= s_sh_d;
            carry_q     <= c_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases on WIDTH=8, randomised runs on
// WIDTH 1, 8 and 16. Inputs and outputs are handled on the falling clock edge.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready, carry;
  logic [7:0] a, b, sum;
  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry)
  );

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {8'b0, c};
  endfunction

  // Present operands until accepted; returns on the falling edge after the accept edge.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int n = 0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(model8(x, y, c));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume8(input string tag);
    logic [8:0] e;
    out_ready = 1'b1;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 64'({carry, sum}), 64'(e));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Randomised runs on the other widths, each with its own scoreboard.
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int W = (g == 0) ? 1 : 16;
    logic         rn, iv, ir, ci, ov, orr, co;
    logic [W-1:0] ra, rb, rs;
    logic [W:0]   q[$];
    bit           done = 1'b0;

    serial_adder #(.WIDTH(W)) u_side (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .cin(ci), .out_valid(ov), .out_ready(orr),
      .sum(rs), .carry(co)
    );

    initial begin
      int nres = 0;
      int cyc = 0;
      logic [W:0] e;
      rn = 1'b0; iv = 1'b0; ci = 1'b0; orr = 1'b0; ra = '0; rb = '0;
      repeat (3) @(negedge clk);
      rn = 1'b1;
      check_eq($sformatf("w%0d_rst_valid", W), 64'(ov), 64'd0);
      check_eq($sformatf("w%0d_rst_ready", W), 64'(ir), 64'd1);
      while (nres < 1000 && cyc < 60000) begin
        orr = ($urandom_range(0, 3) != 0);
        if (ov && orr) begin
          if (q.size() == 0) begin
            check_eq($sformatf("w%0d_sb_empty", W), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check_eq($sformatf("w%0d_rand", W), 64'({co, rs}), 64'(e));
          end
          nres++;
        end
        iv = 1'($urandom_range(0, 1));
        ra = W'($urandom);
        rb = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        if (iv && ir) q.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, ci});
        @(negedge clk);
        cyc++;
      end
      check_eq($sformatf("w%0d_rand_count", W), 64'(nres), 64'd1000);
      iv = 1'b0;
      orr = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    int lat;
    int last;
    int nres;
    int cyc;
    logic [8:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_carry", 64'(carry), 64'd0);

    // Basic add with latency measurement
    issue8(8'h0F, 8'h01, 1'b0);
    wait_out(lat);
    check_eq("t1_latency", 64'(lat), 64'd8);
    check_eq("t1_sum_const", 64'({carry, sum}), 64'h010);
    consume8("t1_sum");
    check_eq("t1_idle_ready", 64'(in_ready), 64'd1);

    // Full carry ripple cases
    issue8(8'hFF, 8'h01, 1'b0);
    wait_out(lat);
    check_eq("t2a_const", 64'({carry, sum}), 64'h100);
    consume8("t2a_sum");
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_out(lat);
    check_eq("t2b_const", 64'({carry, sum}), 64'h1FF);
    consume8("t2b_sum");

    // Backpressure with an ignored operand pulse while DONE
    issue8(8'h5A, 8'h3C, 1'b1);
    wait_out(lat);
    check_eq("t3_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_valid", 64'(out_valid), 64'd1);
      check_eq("t3_hold_ready", 64'(in_ready), 64'd0);
      check_eq("t3_hold_sum", 64'({carry, sum}), 64'(model8(8'h5A, 8'h3C, 1'b1)));
      if (i == 1) begin
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      end
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    consume8("t3_sum");
    check_eq("t3_idle_ready", 64'(in_ready), 64'd1);
    check_eq("t3_idle_valid", 64'(out_valid), 64'd0);
    repeat (12) @(negedge clk);
    check_eq("t3_pulse_ignored", 64'(out_valid), 64'd0);

    // Reset in the middle of RUN
    issue8(8'h77, 8'h88, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t4_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t4_rst_sum", 64'(sum), 64'd0);
    check_eq("t4_rst_carry", 64'(carry), 64'd0);
    check_eq("t4_rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    issue8(8'h12, 8'h34, 1'b1);
    wait_out(lat);
    check_eq("t4_const", 64'({carry, sum}), 64'h047);
    consume8("t4_sum");

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    in_valid = 1'b1;
    last = -1;
    nres = 0;
    for (int c = 0; c < 70; c++) begin
      if (out_valid) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("t5_sum", 64'({carry, sum}), 64'(e));
        end else begin
          check_eq("t5_sb_empty", 64'd1, 64'd0);
        end
        if (last >= 0) check_eq("t5_period", 64'(c - last), 64'd10);
        last = c;
        nres++;
      end
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
      if (in_ready) exp_q.push_back(model8(a, b, cin));
      @(negedge clk);
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        check_eq("t5_drain", 64'({carry, sum}), 64'(e));
      end
      @(negedge clk);
      cyc++;
    end
    check_eq("t5_count", 64'(nres >= 6), 64'd1);
    check_eq("t5_drained", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Random operands and stalls on WIDTH=8
    nres = 0;
    cyc = 0;
    while (nres < 1000 && cyc < 40000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("w8_rand", 64'({carry, sum}), 64'(e));
        end else begin
          check_eq("w8_sb_empty", 64'd1, 64'd0);
        end
        nres++;
      end
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) exp_q.push_back(model8(a, b, cin));
      @(negedge clk);
      cyc++;
    end
    check_eq("w8_rand_count", 64'(nres), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b0;

    cyc = 0;
    while (!(g_rand[0].done && g_rand[1].done) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("side_runs_done", 64'(g_rand[0].done && g_rand[1].done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
